rom_read_arbiter: RTL and testbench
===================================

// Module: rom_read_arbiter
// PURPOSE
//  Shares one 8x8 lookup ROM (3-bit address, select, 8-bit data) between NREQ requesters.
//  Round-robin grant; drives ROM address/select; registers read data; returns it to the winner
//  over a valid/ready response handshake. Sits between client FSMs and the ROM instance.
// PARAMETERS
//  NREQ  2  number of requesters (2..8)
//  AW    3  ROM address width
//  DW    8  ROM data width
// PORTS
//  clk        in   1        single clock; all logic on posedge
//  rst        in   1        synchronous, active-high reset
//  req_valid  in   NREQ     per-requester read request
//  req_addr   in   NREQ*AW  flattened addresses; requester i at [i*AW +: AW]
//  req_ready  out  NREQ     one-hot accept; transfer when req_valid[i] & req_ready[i]
//  rsp_valid  out  NREQ     one-hot response valid to granted requester
//  rsp_ready  in   NREQ     per-requester response accept
//  rsp_data   out  DW       registered ROM data (shared bus, qualified by rsp_valid)
//  rom_addr   out  AW       to ROM address
//  rom_sel    out  1        to ROM select; ROM outputs 0 when low
//  rom_data   in   DW       from ROM data (combinational ROM)
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=0 except combinational IDLE grant; rsp_valid=0; rsp_data=0;
//    rom_addr=0; rom_sel=0; last_grant=NREQ-1 (requester 0 wins first).
//  - FSM IDLE -> READ -> RESP -> (IDLE | READ).
//  - IDLE: winner = first i with req_valid[i] searching from last_grant+1, wrapping at NREQ.
//    req_ready = onehot(winner) combinationally, only in IDLE with any req_valid; 0 otherwise.
//    On transfer: latch addr_q=req_addr[winner], grant_q=winner, go READ. No valid -> stay.
//  - READ (1 cycle): rom_sel=1, rom_addr=addr_q; at edge rsp_data<=rom_data; go RESP.
//  - RESP: rsp_valid[grant_q]=1, rsp_data stable until rsp_ready[grant_q]; rsp_ready of
//    other requesters ignored. On accept: last_grant<=grant_q, go IDLE.
//  - rom_sel=1 only in READ; rom_addr holds addr_q in all states.
//  - Latency: rsp_valid rises 2 cycles after accept cycle; min 3 cycles per access.
//  - Fairness: requester that was just served has lowest priority next arbitration.
//  - Requester dropping req_valid before acceptance: not granted, no side effect.
//  - Reset mid-operation (READ/RESP): back to IDLE next edge, response discarded, never
//    redelivered; requester must re-issue.
// CONFIGURATION
//  ROM_ARB_BURST_EN defined: extra input req_burst[NREQ]; latched on accept. Burst read
//    returns 8 beats: addr_q, addr_q+1, ... modulo 2^AW (7 wraps to 0). After each accepted
//    beat with beats<7 go RESP->READ (grant held, no re-arbitration); extra output rsp_last
//    high with final beat (and with every single-read response).
//  Not defined: no req_burst/rsp_last ports; every request is a single beat.
// STRUCTURE
//  Package rom_arb_pkg: state encoding (IDLE/READ/RESP), AW/DW constants, BURST_BEATS=8.
//  Sub-module rr_pick: NREQ-wide round-robin priority picker (req vector, last_grant ->
//  onehot + index, purely combinational). Rest in rom_read_arbiter.
// TESTING (bench instantiates real ROM: 0:01 1:03 2:09 3:31 4:71 5:39 6:41 7:81)
//  1 Reset then idle: rsp_valid=0, rsp_data=00, rom_sel=0 for 10 cycles.
//  2 req0 addr=3 -> req_ready[0] same cycle, rom_sel=1 with rom_addr=3 next,
//    rsp_valid[0] with rsp_data=31 two cycles after accept.
//  3 req0 and req1 valid continuously (addr 6 / 7) -> grants alternate 0,1,0,1;
//    data 41,81,41,81.
//  4 rsp_ready[0] held low 5 cycles -> rsp_valid/rsp_data=71 (addr 4) stable, no new
//    grant to req1 until accept.
//  5 rst asserted in RESP -> rsp_valid=0 next cycle, state IDLE, req0 wins next.
//  6 (BURST_EN) req1 burst addr=5 -> 39,41,81,01,03,09,31,71; rsp_last on beat 8 only.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared encodings and constants for the ROM read arbiter.
// Optional burst mode is enabled by defining ROM_ARB_BURST_EN.
package rom_arb_pkg;

    localparam int ROM_AW      = 3;
    localparam int ROM_DW      = 8;
    localparam int BURST_BEATS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rom_read_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester after i_last wins,
// so the most recently served requester has the lowest priority.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    int w_best_d;
    int w_d;

    // Distance from i_last+1 going forward with wrap; smallest distance wins.
    always_comb begin
        w_best_d = NREQ;
        w_d      = 0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (i_req[i]) begin
                w_d = (i + NREQ - 1 - int'(i_last)) % NREQ;
                if (w_d < w_best_d) begin
                    w_best_d = w_d;
                    o_idx    = IW'(i);
                    o_any    = 1'b1;
                end
            end
        end
        o_onehot = o_any ? (NREQ'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one combinational ROM between NREQ requesters.
// Define ROM_ARB_BURST_EN to add req_burst/rsp_last and 8-beat burst reads.
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = ROM_AW,
    parameter int DW   = ROM_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]    req_ready,
`ifdef ROM_ARB_BURST_EN
    input  logic [NREQ-1:0]    req_burst,
    output logic               rsp_last,
`endif
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [DW-1:0]      rsp_data,
    output logic [AW-1:0]      rom_addr,
    output logic               rom_sel,
    input  logic [DW-1:0]      rom_data
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(BURST_BEATS);

    state_t            r_state;
    logic [IW-1:0]     r_last_grant;
    logic [IW-1:0]     r_grant;
    logic [AW-1:0]     r_addr;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [DW-1:0]     r_rsp_data;
    logic              r_rom_sel;
`ifdef ROM_ARB_BURST_EN
    logic              r_burst;
    logic [BW-1:0]     r_beat;
    logic              r_last;
`endif

    logic [NREQ-1:0]   w_pick_onehot;
    logic [IW-1:0]     w_pick_idx;
    logic              w_pick_any;
    logic              w_accept_req;
    logic              w_accept_rsp;
    logic [AW-1:0]     w_win_addr;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .i_req    (req_valid),
        .i_last   (r_last_grant),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    assign w_accept_req = (r_state == ST_IDLE) && w_pick_any;
    assign w_accept_rsp = (r_state == ST_RESP) && rsp_ready[r_grant];
    assign w_win_addr   = req_addr[w_pick_idx*AW +: AW];

    assign req_ready = w_accept_req ? w_pick_onehot : '0;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rom_addr  = r_addr;
    assign rom_sel   = r_rom_sel;
`ifdef ROM_ARB_BURST_EN
    assign rsp_last  = r_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= IW'(NREQ - 1);
            r_grant      <= '0;
            r_addr       <= '0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_rom_sel    <= 1'b0;
`ifdef ROM_ARB_BURST_EN
            r_burst      <= 1'b0;
            r_beat       <= '0;
            r_last       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept_req) begin
                        r_addr    <= w_win_addr;
                        r_grant   <= w_pick_idx;
                        r_rom_sel <= 1'b1;
                        r_state   <= ST_READ;
`ifdef ROM_ARB_BURST_EN
                        r_burst   <= req_burst[w_pick_idx];
                        r_beat    <= '0;
`endif
                    end
                end
                ST_READ: begin
                    r_rsp_data  <= rom_data;
                    r_rom_sel   <= 1'b0;
                    r_rsp_valid <= NREQ'(1) << r_grant;
                    r_state     <= ST_RESP;
`ifdef ROM_ARB_BURST_EN
                    r_last      <= !r_burst || (r_beat == BW'(BURST_BEATS - 1));
`endif
                end
                ST_RESP: begin
                    if (w_accept_rsp) begin
                        r_rsp_valid <= '0;
`ifdef ROM_ARB_BURST_EN
                        r_last      <= 1'b0;
                        // Burst continues on the same grant without re-arbitrating.
                        if (r_burst && (r_beat != BW'(BURST_BEATS - 1))) begin
                            r_beat    <= r_beat + BW'(1);
                            r_addr    <= r_addr + AW'(1);
                            r_rom_sel <= 1'b1;
                            r_state   <= ST_READ;
                        end else begin
                            r_last_grant <= r_grant;
                            r_state      <= ST_IDLE;
                        end
`else
                        r_last_grant <= r_grant;
                        r_state      <= ST_IDLE;
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter against a behavioural 8x8 ROM.
// Burst checks are compiled in when ROM_ARB_BURST_EN is defined.
module tb_rom_read_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [5:0] req_addr;
    logic [1:0] req_ready;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [7:0] rsp_data;
    logic [2:0] rom_addr;
    logic       rom_sel;
    logic [7:0] rom_data;
`ifdef ROM_ARB_BURST_EN
    logic [1:0] req_burst;
    logic       rsp_last;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_tab(input logic [2:0] a);
        case (a)
            3'd0: return 8'h01;
            3'd1: return 8'h03;
            3'd2: return 8'h09;
            3'd3: return 8'h31;
            3'd4: return 8'h71;
            3'd5: return 8'h39;
            3'd6: return 8'h41;
            default: return 8'h81;
        endcase
    endfunction

    always_comb rom_data = rom_sel ? rom_tab(rom_addr) : 8'h00;

    rom_read_arbiter #(.NREQ(2), .AW(3), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
`ifdef ROM_ARB_BURST_EN
        .req_burst (req_burst),
        .rsp_last  (rsp_last),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rom_addr  (rom_addr),
        .rom_sel   (rom_sel),
        .rom_data  (rom_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [1:0] exp_gnt [4];
    logic [7:0] exp_dat [4];
    logic [7:0] exp_burst [8];

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_addr  = 6'd0;
        rsp_ready = 2'b00;
`ifdef ROM_ARB_BURST_EN
        req_burst = 2'b00;
`endif
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_dat = '{8'h41, 8'h81, 8'h41, 8'h81};
        exp_burst = '{8'h39, 8'h41, 8'h81, 8'h01, 8'h03, 8'h09, 8'h31, 8'h71};

        // 1: reset then idle
        do_reset();
        for (int c = 0; c < 10; c++) begin
            chk("idle_rsp_valid", 8'(rsp_valid), 8'h00);
            chk("idle_rsp_data", rsp_data, 8'h00);
            chk("idle_rom_sel", 8'(rom_sel), 8'h00);
            step();
        end

        // 2: single read, req0 addr 3
        rsp_ready = 2'b11;
        req_addr  = {3'd0, 3'd3};
        req_valid = 2'b01;
        #1;
        chk("t2_req_ready", 8'(req_ready), 8'h01);
        step();
        req_valid = 2'b00;
        chk("t2_rom_sel", 8'(rom_sel), 8'h01);
        chk("t2_rom_addr", 8'(rom_addr), 8'h03);
        chk("t2_rsp_valid_read", 8'(rsp_valid), 8'h00);
        step();
        chk("t2_rsp_valid", 8'(rsp_valid), 8'h01);
        chk("t2_rsp_data", rsp_data, 8'h31);
        chk("t2_rom_sel_resp", 8'(rom_sel), 8'h00);
`ifdef ROM_ARB_BURST_EN
        chk("t2_rsp_last", 8'(rsp_last), 8'h01);
`endif
        step();
        chk("t2_rsp_valid_done", 8'(rsp_valid), 8'h00);
        chk("t2_rom_addr_hold", 8'(rom_addr), 8'h03);

        // 3: both requesters continuous, grants alternate
        do_reset();
        rsp_ready = 2'b11;
        req_addr  = {3'd7, 3'd6};
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk("t3_req_ready", 8'(req_ready), 8'(exp_gnt[g]));
            step();
            step();
            chk("t3_rsp_valid", 8'(rsp_valid), 8'(exp_gnt[g]));
            chk("t3_rsp_data", rsp_data, exp_dat[g]);
            step();
        end
        req_valid = 2'b00;

        // 4: response backpressure, other requester's ready ignored
        do_reset();
        req_addr  = {3'd7, 3'd4};
        req_valid = 2'b11;
        rsp_ready = 2'b10;
        #1;
        chk("t4_req_ready", 8'(req_ready), 8'h01);
        step();
        step();
        for (int c = 0; c < 5; c++) begin
            chk("t4_rsp_valid_hold", 8'(rsp_valid), 8'h01);
            chk("t4_rsp_data_hold", rsp_data, 8'h71);
            chk("t4_no_grant", 8'(req_ready), 8'h00);
            step();
        end
        rsp_ready = 2'b01;
        step();
        #1;
        chk("t4_rsp_valid_done", 8'(rsp_valid), 8'h00);
        chk("t4_next_grant", 8'(req_ready), 8'h02);
        req_valid = 2'b00;
        rsp_ready = 2'b00;

        // 5: reset asserted during RESP
        do_reset();
        req_addr  = {3'd2, 3'd1};
        req_valid = 2'b10;
        rsp_ready = 2'b00;
        step();
        req_valid = 2'b00;
        step();
        chk("t5_rsp_valid_pre", 8'(rsp_valid), 8'h02);
        chk("t5_rsp_data_pre", rsp_data, 8'h09);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rsp_valid_rst", 8'(rsp_valid), 8'h00);
        chk("t5_rsp_data_rst", rsp_data, 8'h00);
        chk("t5_rom_sel_rst", 8'(rom_sel), 8'h00);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        chk("t5_req0_wins", 8'(req_ready), 8'h01);
        step();
        req_valid = 2'b00;
        step();
        chk("t5_rsp_valid_new", 8'(rsp_valid), 8'h01);
        chk("t5_rsp_data_new", rsp_data, 8'h03);
        step();

`ifdef ROM_ARB_BURST_EN
        // 6: burst from requester 1 starting at address 5
        do_reset();
        req_addr  = {3'd5, 3'd0};
        req_burst = 2'b10;
        req_valid = 2'b10;
        rsp_ready = 2'b11;
        #1;
        chk("t6_req_ready", 8'(req_ready), 8'h02);
        step();
        req_valid = 2'b00;
        req_burst = 2'b00;
        step();
        for (int b = 0; b < 8; b++) begin
            chk("t6_rsp_valid", 8'(rsp_valid), 8'h02);
            chk("t6_rsp_data", rsp_data, exp_burst[b]);
            chk("t6_rsp_last", 8'(rsp_last), (b == 7) ? 8'h01 : 8'h00);
            step();
            if (b < 7) begin
                chk("t6_no_grant", 8'(req_ready), 8'h00);
                step();
            end
        end
        chk("t6_rsp_valid_done", 8'(rsp_valid), 8'h00);
        chk("t6_rom_sel_done", 8'(rom_sel), 8'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
